// File: rtl/counter_sched_if.sv
// Request/grant bundle between requester logic and the shared-counter scheduler.
// The scheduler binds to the slave modport and the requester side to the master modport.
interface counter_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 3
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] len;
  logic [NREQ-1:0]   grant;
  logic [W-1:0]      count;
  logic              busy;
  logic [NREQ-1:0]   done;

  modport master (
    output req, len,
    input  grant, count, busy, done
  );

  modport slave (
    input  req, len,
    output grant, count, busy, done
  );
endinterface

// File: rtl/counter_sched.sv
// Round-robin scheduler that lends a shared W-bit up-counter to one requester at a time.
// Each run clears the counter, counts it up to the latched target, and then pulses done.
module counter_sched #(
  parameter int NREQ = 4,
  parameter int W    = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  counter_sched_if.slave  io_bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, r_done, w_grant_nxt, w_done_nxt;
  logic [W-1:0]    r_count, r_target, w_count_nxt, w_target_nxt;
  logic [IW-1:0]   r_last, r_winner, w_last_nxt, w_winner_nxt, w_pick;
  logic            r_busy;
  logic            w_any_req, w_terminal, w_win_req;

  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [IW-1:0]   last);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = {IW{1'b0}};
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(last) + k) % NREQ;
      pick  = (!found && req[idx]) ? IW'(idx) : pick;
      found = found | req[idx];
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  assign w_any_req  = |io_bus.req;
  assign w_pick     = rr_pick(io_bus.req, r_last);
  assign w_win_req  = io_bus.req[r_winner];
  assign w_terminal = (r_count == r_target);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; terminal count outranks a same-cycle request drop
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_nxt = ST_RUN;
        else           w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_terminal)      w_state_nxt = ST_FIN;
        else if (!w_win_req) w_state_nxt = ST_IDLE;
        else                 w_state_nxt = ST_RUN;
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and run bookkeeping
  always_comb begin
    w_grant_nxt  = r_grant;
    w_done_nxt   = r_done;
    w_count_nxt  = r_count;
    w_target_nxt = r_target;
    w_last_nxt   = r_last;
    w_winner_nxt = r_winner;
    case (r_state)
      ST_IDLE: begin
        w_done_nxt = {NREQ{1'b0}};
        if (w_any_req) begin
          w_grant_nxt  = onehot(w_pick);
          w_count_nxt  = {W{1'b0}};
          w_target_nxt = io_bus.len[int'(w_pick)*W +: W];
          w_last_nxt   = w_pick;
          w_winner_nxt = w_pick;
        end else begin
          w_grant_nxt = {NREQ{1'b0}};
          w_count_nxt = {W{1'b0}};
        end
      end
      ST_RUN: begin
        if (w_terminal) begin
          w_grant_nxt = {NREQ{1'b0}};
          w_done_nxt  = onehot(r_winner);
        end else if (!w_win_req) begin
          w_grant_nxt = {NREQ{1'b0}};
          w_count_nxt = {W{1'b0}};
        end else begin
          w_count_nxt = r_count + {{(W-1){1'b0}}, 1'b1};
        end
      end
      ST_FIN: begin
        w_done_nxt  = {NREQ{1'b0}};
        w_grant_nxt = {NREQ{1'b0}};
        w_count_nxt = {W{1'b0}};
      end
      default: begin
        w_grant_nxt = {NREQ{1'b0}};
        w_done_nxt  = {NREQ{1'b0}};
        w_count_nxt = {W{1'b0}};
      end
    endcase
  end

  // Output and bookkeeping registers; requester 0 has first priority out of reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant  <= {NREQ{1'b0}};
      r_done   <= {NREQ{1'b0}};
      r_count  <= {W{1'b0}};
      r_target <= {W{1'b0}};
      r_last   <= IW'(NREQ - 1);
      r_winner <= {IW{1'b0}};
      r_busy   <= 1'b0;
    end else begin
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_count  <= w_count_nxt;
      r_target <= w_target_nxt;
      r_last   <= w_last_nxt;
      r_winner <= w_winner_nxt;
      r_busy   <= (w_state_nxt == ST_RUN);
    end
  end

  assign io_bus.grant = r_grant;
  assign io_bus.done  = r_done;
  assign io_bus.count = r_count;
  assign io_bus.busy  = r_busy;
endmodule

// File: tb/tb_counter_sched.sv
// Directed and randomized bench for counter_sched; expected traces come from a
// transaction-level model (round-robin pick plus the per-run count/done timeline).
module tb_counter_sched;
  localparam int NREQ = 4;
  localparam int W    = 3;
  localparam int LW   = NREQ * W;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  int   mdl_last = NREQ - 1;

  counter_sched_if #(.NREQ(NREQ), .W(W)) bus();

  counter_sched #(.NREQ(NREQ), .W(W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin reference: first requester after the last winner, with wrap.
  function automatic int rr(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(mdl_last + k) % NREQ]) return (mdl_last + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic check_out(input string tag, input logic [NREQ-1:0] g,
                           input logic [W-1:0] c, input logic b,
                           input logic [NREQ-1:0] d);
    n_checks++;
    assert (bus.grant === g) else begin
      n_err++;
      $error("FAIL %s grant observed=%b expected=%b", tag, bus.grant, g);
    end
    n_checks++;
    assert (bus.count === c) else begin
      n_err++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, bus.count, c);
    end
    n_checks++;
    assert (bus.busy === b) else begin
      n_err++;
      $error("FAIL %s busy observed=%b expected=%b", tag, bus.busy, b);
    end
    n_checks++;
    assert (bus.done === d) else begin
      n_err++;
      $error("FAIL %s done observed=%b expected=%b", tag, bus.done, d);
    end
  endtask

  // One run from idle: requester drops req after observing count==ab (ab>target means never).
  task automatic run_txn(input logic [NREQ-1:0] mask, input logic [LW-1:0] lens,
                         input int ab, input bit scramble, input string tag);
    int              win;
    int              t;
    logic [NREQ-1:0] oh;
    win     = rr(mask);
    t       = int'(lens[win*W +: W]);
    oh      = '0;
    oh[win] = 1'b1;
    bus.req = mask;
    bus.len = lens;
    for (int c = 0; c <= t; c++) begin
      @(negedge clk);
      check_out(tag, oh, W'(c), 1'b1, '0);
      if (scramble) bus.len = LW'($urandom);
      if (c == ab) bus.req = '0;
      if (c == ab && ab < t) begin
        @(negedge clk);
        check_out({tag, "_abort"}, '0, '0, 1'b0, '0);
        mdl_last = win;
        return;
      end
    end
    @(negedge clk);
    check_out({tag, "_done"}, '0, W'(t), 1'b0, oh);
    bus.req = '0;
    @(negedge clk);
    check_out({tag, "_fin"}, '0, '0, 1'b0, '0);
    mdl_last = win;
  endtask

  initial begin
    int              win;
    logic [NREQ-1:0] oh;
    rst     = 1'b1;
    bus.req = '0;
    bus.len = '0;
    repeat (10) @(negedge clk);
    check_out("reset", '0, '0, 1'b0, '0);
    rst = 1'b0;

    run_txn(4'b0001, 12'h003, 99, 1'b0, "single");
    run_txn(4'b0100, 12'h000, 99, 1'b0, "zero_len");
    run_txn(4'b0100, 12'h1C0, 99, 1'b0, "max_len");
    run_txn(4'b0010, 12'h028, 2, 1'b0, "abort");
    run_txn(4'b0010, 12'h028, 5, 1'b0, "abort_at_term");
    run_txn(4'b0001, 12'h002, 99, 1'b1, "len_change");

    // Reset in the middle of a run, then fairness with all requesters active.
    bus.req = 4'b0001;
    bus.len = 12'h006;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      check_out("pre_rst", 4'b0001, W'(c), 1'b1, '0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_out("mid_rst", '0, '0, 1'b0, '0);
    rst      = 1'b0;
    mdl_last = NREQ - 1;
    bus.req  = 4'b1111;
    bus.len  = 12'h249;
    for (int g = 0; g < 5; g++) begin
      win     = rr(bus.req);
      oh      = '0;
      oh[win] = 1'b1;
      for (int c = 0; c <= 1; c++) begin
        @(negedge clk);
        check_out("rr_grant", oh, W'(c), 1'b1, '0);
      end
      @(negedge clk);
      check_out("rr_done", '0, 3'd1, 1'b0, oh);
      @(negedge clk);
      if (g == 4) bus.req = '0;
      check_out("rr_gap", '0, '0, 1'b0, '0);
      mdl_last = win;
    end

    for (int i = 0; i < 40; i++) begin
      run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), LW'($urandom),
              int'($urandom_range(0, 9)), 1'($urandom), "rand");
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_out("rand_idle", '0, '0, 1'b0, '0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
